// File: rtl/can_bit_timing_sync_if.sv
// can_bit_timing_sync_if: configuration, bus input and timing strobes of the CAN bit-timing logic.
interface can_bit_timing_sync_if #(
  parameter int BRP_W  = 8,
  parameter int TSEG_W = 4,
  parameter int SJW_W  = 2
);
  logic              en;
  logic [BRP_W-1:0]  brp;
  logic [TSEG_W-1:0] tseg1;
  logic [TSEG_W-1:0] tseg2;
  logic [SJW_W-1:0]  sjw;
  logic              rx;
  logic              hard_sync_en;
  logic              tq_pulse;
  logic              bit_start;
  logic              sample_point;
  logic              sampled_bit;
  logic              resync_pulse;
  modport master (
    output en, brp, tseg1, tseg2, sjw, rx, hard_sync_en,
    input  tq_pulse, bit_start, sample_point, sampled_bit, resync_pulse
  );
  modport slave (
    input  en, brp, tseg1, tseg2, sjw, rx, hard_sync_en,
    output tq_pulse, bit_start, sample_point, sampled_bit, resync_pulse
  );
endinterface

// File: rtl/can_bit_timing_sync.sv
// can_bit_timing_sync: CAN 2.0B bit timing with hard sync and SJW-limited resync.
// Define CAN_BTL_TRIPLE_SAMPLE_EN for majority-of-three sampling at the sample point.
module can_bit_timing_sync #(
  parameter int BRP_W  = 8,
  parameter int TSEG_W = 4,
  parameter int SJW_W  = 2
) (
  input logic clk,
  input logic rst_n,
  can_bit_timing_sync_if.slave bus
);
  localparam int SW = TSEG_W + 1;
  typedef enum logic [1:0] {SYNC, TSEG1, TSEG2} state_t;
  state_t           state, state_n;
  logic [BRP_W-1:0] tq_cnt, tq_cnt_n;
  logic [SW-1:0]    seg_cnt, seg_cnt_n, ext, ext_n;
  logic [SW-1:0]    t1, t2, sjw_e, err2, shorten;
  logic             rx_q, rx_q_n, edge_pending, edge_pending_n, rs_done, rs_done_n;
  logic             tq_pulse, tq_pulse_n, bit_start, bit_start_n;
  logic             sample_point, sample_point_n, resync_pulse, resync_pulse_n;
  logic             sampled_bit, sampled_bit_n;
  logic             tick, edge_tq, hard, resync, tseg2_end, sample_val;
  assign tick    = tq_cnt == bus.brp;
  assign edge_tq = edge_pending | (rx_q & ~bus.rx);
  assign hard    = tick & edge_tq & bus.hard_sync_en;
  assign resync  = tick & edge_tq & ~bus.hard_sync_en & ~rs_done & (state != SYNC);
  assign t1      = (bus.tseg1 == '0) ? SW'(1) : SW'(bus.tseg1);
  assign t2      = (bus.tseg2 == '0) ? SW'(1) : SW'(bus.tseg2);
  assign sjw_e   = SW'(bus.sjw) + SW'(1);
  assign err2    = t2 - seg_cnt + SW'(1);
  // In TSEG2 rs_done can only come from an early resync of this segment, which shortens it
  assign shorten   = (resync | rs_done) ? sjw_e : SW'(0);
  assign tseg2_end = ({1'b0, seg_cnt} + {1'b0, shorten}) >= {1'b0, t2};
`ifdef CAN_BTL_TRIPLE_SAMPLE_EN
  logic [1:0] hist;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) hist <= 2'b11;
    else if (!bus.en) hist <= 2'b11;
    else if (tick) hist <= {hist[0], bus.rx};
  assign sample_val = (hist[1] & hist[0]) | (bus.rx & (hist[1] | hist[0]));
`else
  assign sample_val = bus.rx;
`endif
  always_comb begin
    tq_cnt_n       = tick ? '0 : tq_cnt + BRP_W'(1);
    rx_q_n         = bus.rx;
    edge_pending_n = ~tick & edge_tq;
    state_n        = state;
    seg_cnt_n      = seg_cnt;
    ext_n          = ext;
    rs_done_n      = rs_done;
    tq_pulse_n     = tick;
    bit_start_n    = 1'b0;
    sample_point_n = 1'b0;
    resync_pulse_n = resync;
    sampled_bit_n  = sampled_bit;
    if (hard) begin
      state_n     = TSEG1;
      seg_cnt_n   = SW'(1);
      ext_n       = '0;
      rs_done_n   = 1'b0;
      bit_start_n = 1'b1;
    end else if (tick) begin
      rs_done_n = rs_done | resync;
      case (state)
        SYNC: begin
          state_n   = TSEG1;
          seg_cnt_n = SW'(1);
        end
        TSEG1: begin
          ext_n = resync ? ((seg_cnt < sjw_e) ? seg_cnt : sjw_e) : ext;
          if (seg_cnt == t1 + ext_n) begin
            state_n        = TSEG2;
            seg_cnt_n      = SW'(1);
            ext_n          = '0;
            rs_done_n      = 1'b0;
            sample_point_n = 1'b1;
            sampled_bit_n  = sample_val;
          end else
            seg_cnt_n = seg_cnt + SW'(1);
        end
        default: begin
          // Small phase error: the edge TQ itself becomes SYNC of the next bit
          if (resync && err2 <= sjw_e) begin
            state_n     = TSEG1;
            seg_cnt_n   = SW'(1);
            bit_start_n = 1'b1;
          end else if (tseg2_end) begin
            state_n     = SYNC;
            seg_cnt_n   = '0;
            bit_start_n = 1'b1;
          end else
            seg_cnt_n = seg_cnt + SW'(1);
        end
      endcase
    end
    if (!bus.en) begin
      tq_cnt_n       = '0;
      rx_q_n         = 1'b1;
      edge_pending_n = 1'b0;
      state_n        = SYNC;
      seg_cnt_n      = '0;
      ext_n          = '0;
      rs_done_n      = 1'b0;
      tq_pulse_n     = 1'b0;
      bit_start_n    = 1'b0;
      sample_point_n = 1'b0;
      resync_pulse_n = 1'b0;
      sampled_bit_n  = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tq_cnt       <= '0;
      rx_q         <= 1'b1;
      edge_pending <= 1'b0;
      state        <= SYNC;
      seg_cnt      <= '0;
      ext          <= '0;
      rs_done      <= 1'b0;
      tq_pulse     <= 1'b0;
      bit_start    <= 1'b0;
      sample_point <= 1'b0;
      resync_pulse <= 1'b0;
      sampled_bit  <= 1'b1;
    end else begin
      tq_cnt       <= tq_cnt_n;
      rx_q         <= rx_q_n;
      edge_pending <= edge_pending_n;
      state        <= state_n;
      seg_cnt      <= seg_cnt_n;
      ext          <= ext_n;
      rs_done      <= rs_done_n;
      tq_pulse     <= tq_pulse_n;
      bit_start    <= bit_start_n;
      sample_point <= sample_point_n;
      resync_pulse <= resync_pulse_n;
      sampled_bit  <= sampled_bit_n;
    end
  assign bus.tq_pulse     = tq_pulse;
  assign bus.bit_start    = bit_start;
  assign bus.sample_point = sample_point;
  assign bus.resync_pulse = resync_pulse;
  assign bus.sampled_bit  = sampled_bit;
endmodule

// File: tb/tb_can_bit_timing_sync.sv
// tb_can_bit_timing_sync: directed scenarios plus random bus traffic checked against a TQ-position model.
module tb_can_bit_timing_sync;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  can_bit_timing_sync_if bus();
  can_bit_timing_sync dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0, cyc = 0, tq_n = 0;
  int bs_q[$], sp_q[$], rp_q[$];
  // Model: position of the current TQ within the bit (0 = SYNC), counted from the bit start
  int m_cnt, m_pos, m_ext;
  bit m_rxq, m_pend, m_rs, m_short, m_sb;
  bit cap[$];
  logic [4:0] m_out;
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic int eff(input int v);
    return v == 0 ? 1 : v;
  endfunction
  function automatic bit sample();
`ifdef CAN_BTL_TRIPLE_SAMPLE_EN
    return (cap[0] & cap[1]) | (cap[0] & cap[2]) | (cap[1] & cap[2]);
`else
    return cap[2];
`endif
  endfunction
  task automatic model_reset();
    m_cnt = 0; m_pos = 0; m_ext = 0;
    m_rxq = 1; m_pend = 0; m_rs = 0; m_short = 0; m_sb = 1;
    cap = '{1'b1, 1'b1, 1'b1};
    m_out = 5'b00001;
  endtask
  task automatic model_step();
    int t1, t2, sj, p, l1, k;
    bit tk, ed, rsy, bs_o, sp_o, rp_o;
    if (!rst_n || !bus.en) model_reset();
    else begin
      t1 = eff(int'(bus.tseg1)); t2 = eff(int'(bus.tseg2)); sj = int'(bus.sjw) + 1;
      tk = (m_cnt == int'(bus.brp));
      ed = m_pend || (m_rxq && !bus.rx);
      m_rxq = bus.rx;
      m_cnt = tk ? 0 : m_cnt + 1;
      m_pend = tk ? 1'b0 : ed;
      bs_o = 0; sp_o = 0; rp_o = 0;
      if (tk) begin
        cap.push_back(bus.rx);
        void'(cap.pop_front());
        p = m_pos;
        if (ed && bus.hard_sync_en) begin
          m_pos = 1; m_ext = 0; m_rs = 0; m_short = 0; bs_o = 1;
        end else begin
          rsy = ed && !m_rs && p != 0;
          if (rsy) begin m_rs = 1; rp_o = 1; end
          l1 = t1 + m_ext;
          if (p == 0) m_pos = 1;
          else if (p <= l1) begin
            if (rsy) m_ext = (p < sj) ? p : sj;
            if (p == t1 + m_ext) begin sp_o = 1; m_rs = 0; m_sb = sample(); end
            m_pos = p + 1;
          end else begin
            k = p - l1;
            if (rsy) m_short = 1;
            if (rsy && t2 - k + 1 <= sj) begin
              m_pos = 1; m_ext = 0; m_short = 0; bs_o = 1;
            end else if (k >= t2 - (m_short ? sj : 0)) begin
              m_pos = 0; m_ext = 0; m_short = 0; bs_o = 1;
            end else m_pos = p + 1;
          end
        end
      end
      m_out = {tk, bs_o, sp_o, rp_o, m_sb};
    end
  endtask
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    chk("outs", int'({bus.tq_pulse, bus.bit_start, bus.sample_point, bus.resync_pulse, bus.sampled_bit}), int'(m_out));
    cyc++;
    if (bus.tq_pulse) tq_n++;
    if (bus.bit_start) bs_q.push_back(cyc);
    if (bus.sample_point) sp_q.push_back(cyc);
    if (bus.resync_pulse) rp_q.push_back(cyc);
  endtask
  task automatic start_run();
    bus.en = 1'b1;
    cyc = 0; tq_n = 0;
    bs_q.delete(); sp_q.delete(); rp_q.delete();
  endtask
  initial begin
    bus.en = 1'b0; bus.brp = 8'd1; bus.tseg1 = 4'd5; bus.tseg2 = 4'd2; bus.sjw = 2'd1;
    bus.rx = 1'b1; bus.hard_sync_en = 1'b0;
    model_reset();
    repeat (3) step();
    chk("reset_outs", int'({bus.tq_pulse, bus.bit_start, bus.sample_point, bus.resync_pulse, bus.sampled_bit}), 1);
    rst_n = 1'b1;
    step();
    // Nominal bit: 8 TQ of 2 clocks, sample after 6 TQ
    start_run();
    repeat (44) step();
    chk("nom_first_bs", bs_q[0], 16);
    chk("nom_bit_len", bs_q[1] - bs_q[0], 16);
    chk("nom_first_sp", sp_q[0], 12);
    chk("nom_sp_after_bs", sp_q[1] - bs_q[0], 12);
    chk("nom_tq_count", tq_n, 22);
    chk("nom_no_resync", rp_q.size(), 0);
    // Hard sync on a falling edge during TSEG2 TQ1
    bus.hard_sync_en = 1'b1; bus.rx = 1'b0;
    bs_q.delete(); sp_q.delete();
    repeat (14) step();
    chk("hs_bs", bs_q[0], 46);
    chk("hs_sp", sp_q[0], 56);
    chk("hs_sbit", int'(bus.sampled_bit), 0);
    bus.hard_sync_en = 1'b0; bus.rx = 1'b1;
    repeat (8) step();
    rst_n = 1'b0;
    repeat (3) begin
      step();
      chk("rst_mid", int'({bus.tq_pulse, bus.bit_start, bus.sample_point, bus.resync_pulse, bus.sampled_bit}), 1);
    end
    bus.en = 1'b0; bus.sjw = 2'd0;
    rst_n = 1'b1;
    step();
    // Late resync in TSEG1 TQ1, then a second edge just before the sample tick (rx 1,1,0 captures)
    start_run();
    repeat (2) step();
    bus.rx = 1'b0;
    repeat (6) step();
    bus.rx = 1'b1;
    repeat (4) step();
    bus.rx = 1'b0;
    repeat (2) step();
    chk("late_rp_cycle", rp_q[0], 4);
    chk("late_rp_once", rp_q.size(), 1);
    chk("late_sp_delayed", sp_q[0], 14);
    chk("late_no_bs", bs_q.size(), 0);
`ifdef CAN_BTL_TRIPLE_SAMPLE_EN
    chk("sample_110", int'(bus.sampled_bit), 1);
`else
    chk("sample_110", int'(bus.sampled_bit), 0);
`endif
    // Random traffic over random legal configurations
    for (int ep = 0; ep < 24; ep++) begin
      bus.en = 1'b0;
      repeat (2) step();
      bus.brp = 8'($urandom_range(0, 3));
      bus.tseg1 = 4'($urandom_range(0, 9));
      bus.tseg2 = 4'($urandom_range(0, 9));
      bus.sjw = 2'($urandom_range(0, 3));
      bus.hard_sync_en = 1'($urandom_range(0, 1));
      step();
      bus.en = 1'b1;
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(0, 9) == 0) bus.rx = ~bus.rx;
        if ($urandom_range(0, 59) == 0) bus.hard_sync_en = ~bus.hard_sync_en;
        if ($urandom_range(0, 299) == 0) begin
          rst_n = 1'b0;
          repeat (3) step();
          rst_n = 1'b1;
        end
        step();
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
